fb_write_scheduler: RTL and testbench
=====================================

// Module: fb_write_scheduler
// PURPOSE
//  Owns the single write port of the dual-port frame buffer (160x120 px, 8-bit, AW=15).
//  Arbitrates two requesters: the camera capture stream (priority, no backpressure) and the
//  processing engine (valid/ready). Also runs a built-in frame-clear sequencer.
//  Sits between capture/processing logic and the buffer's clk/addr_in/data_in/regwrite inputs.
//  The read port is not touched.
// PARAMETERS
//  AW      15     address width of the frame buffer
//  DW      8      pixel data width
//  NPIX    19200  valid pixel locations, 0..NPIX-1; any address >= NPIX is out of range
//  CLR_VAL 8'h00  pixel value written by the clear sequencer
// PORTS
//  clk        in   1    single system clock; all logic is on its rising edge
//  rst        in   1    synchronous, active-high reset
//  cam_we     in   1    camera pixel valid; one pixel per cycle, cannot be stalled
//  cam_addr   in   AW   camera pixel address
//  cam_data   in   DW   camera pixel value
//  proc_req   in   1    processing write request; must hold addr/data stable until granted
//  proc_addr  in   AW   processing write address
//  proc_data  in   DW   processing write value
//  proc_gnt   out  1    combinational; a transfer occurs on the cycle proc_req & proc_gnt
//  clr_start  in   1    pulse: fill the whole frame with CLR_VAL
//  clr_busy   out  1    registered; high while the clear is in progress
//  clr_done   out  1    registered; one-cycle pulse after the last clear write
//  ram_we     out  1    registered; drives the buffer regwrite
//  ram_addr   out  AW   registered; drives the buffer addr_in
//  ram_data   out  DW   registered; drives the buffer data_in
//  drop_cnt   out  16   dropped camera pixels; saturates at 16'hFFFF
//  oor_err    out  1    sticky; set by any out-of-range write attempt
// BEHAVIOUR
//  Reset (rst=1 at an edge): the following are all 0 the next cycle:
//   - outputs ram_we, ram_addr, ram_data, drop_cnt, oor_err, clr_busy, clr_done
//   - the clear counter
//  Reset state is RUN. proc_gnt reads 0 while rst=1.
//  States:
//   - RUN   -> CLEAR on clr_start
//   - CLEAR -> DONE after the write to NPIX-1 is selected
//   - DONE  -> RUN unconditionally (1 cycle)
//  Selection happens every cycle. The winner is registered onto ram_* at the next edge
//  (1-cycle latency). If there is no winner, ram_we=0 and ram_addr/ram_data hold.
//  RUN priority:
//   - In-range cam_we wins. proc_gnt=0 that cycle.
//   - Otherwise an in-range proc_req wins and gets proc_gnt=1.
//  Out-of-range camera pixel: not written; drop_cnt+1; oor_err<=1.
//  Out-of-range proc request:
//   - proc_gnt=1 (consumed so the engine cannot hang), not written, oor_err<=1.
//   - If cam_we is in the same cycle, the out-of-range proc request still waits.
//  clr_start is sampled only in RUN; it is ignored in CLEAR and DONE.
//  The cycle after clr_start: state=CLEAR, clr_busy=1, counter=0.
//  CLEAR:
//   - Every cycle the write (counter, CLR_VAL) is selected and the counter increments.
//   - Exactly NPIX consecutive writes, ascending 0..NPIX-1.
//   - cam_we pixels are dropped (drop_cnt+1 each; oor_err unaffected).
//   - proc_gnt=0.
//  DONE: clr_busy=0, clr_done=1, proc_gnt=0; cam_we is treated as in RUN.
//  Cycle accounting:
//   - clr_start seen at edge T: ram_we for addr 0 appears at T+2; addr NPIX-1 at T+NPIX+1.
//   - clr_done is high during cycle T+NPIX+1.
//  The clear counter is AW bits wide. The compare is counter==NPIX-1, so it never wraps.
//  drop_cnt: +1 per dropped pixel; holds at FFFF. Cleared only by rst.
//  oor_err: cleared only by rst.
//  Reset mid-clear: abort immediately. No further clear writes, no clr_done pulse;
//   the frame stays partially cleared.
//  Writes to address NPIX or above never reach the buffer.
// TESTING
//  rst, then idle 3 cycles -> ram_we=0, drop_cnt=0, oor_err=0, clr_busy=0, proc_gnt=0 during rst
//  proc_req addr=5 data=AA -> proc_gnt=1 same cycle; next cycle ram_we=1, ram_addr=5, ram_data=AA
//  cam_we addr=7 data=11 with proc_req addr=9 -> cam written first; proc_gnt=0, then 1 next cycle; writes at 7 then 9
//  NPIX=16, clr_start, cam_we held high 20 cycles -> 16 writes of 00 to addrs 0..15; clr_done 1 cycle at T+17; drop_cnt=16
//  cam_we addr=NPIX, then proc_req addr=7FFF -> no ram_we; drop_cnt=1; proc_gnt=1; oor_err=1 until rst
//  NPIX=16, rst asserted 5 cycles into clear -> ram_we=0 next cycle; RUN; no clr_done; a later clr_start restarts at addr 0

Source files
------------

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//   Owns the single write port of the dual-port frame buffer. Each cycle it picks
//   at most one write from three sources and registers the winner onto ram_*
//   (one cycle of latency):
//     - the built-in clear sequencer (owns the port while a clear runs),
//     - the camera capture stream (priority, cannot be stalled),
//     - the processing engine (valid/ready handshake via proc_req/proc_gnt).
//   Writes to addresses >= NPIX never reach the buffer. They raise the sticky
//   oor_err flag, and dropped camera pixels are counted in drop_cnt.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   cam_we/addr/data       camera pixel stream (one pixel per cycle, no backpressure)
//   proc_req/addr/data     processing write request, held stable until granted
//   proc_gnt               combinational grant; a transfer occurs on proc_req & proc_gnt
//   clr_start              pulse: fill the whole frame with CLR_VAL
//   clr_busy, clr_done     clear in progress / one-cycle pulse after the last clear write
//   ram_we/addr/data       registered drive of the buffer write port
//   drop_cnt               saturating count of dropped camera pixels
//   oor_err                sticky out-of-range write attempt flag
module fb_write_scheduler #(
    parameter int unsigned   AW      = 15,
    parameter int unsigned   DW      = 8,
    parameter int unsigned   NPIX    = 19200,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_we,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_data,
    input  logic          proc_req,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_data,
    output logic          proc_gnt,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic [15:0]   drop_cnt,
    output logic          oor_err
);

    typedef enum logic [1:0] {
        S_RUN,
        S_CLEAR,
        S_DONE
    } state_t;

    // One extra bit so that NPIX == 2**AW still compares correctly.
    localparam logic [AW:0]   NPIX_W   = (AW+1)'(NPIX);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_data_q;
    logic [15:0]   drop_cnt_q;
    logic          oor_err_q;
    logic          clr_busy_q;
    logic          clr_done_q;

    logic          cam_inr;
    logic          proc_inr;
    logic          cam_win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          gnt;
    logic          drop_inc;
    logic          oor_set;

    assign cam_inr  = ({1'b0, cam_addr}  < NPIX_W);
    assign proc_inr = ({1'b0, proc_addr} < NPIX_W);
    assign cam_win  = cam_we && cam_inr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        gnt      = 1'b0;
        drop_inc = 1'b0;
        oor_set  = 1'b0;

        unique case (state_q)
            S_RUN, S_DONE: begin
                if (cam_win) begin
                    sel_we   = 1'b1;
                    sel_addr = cam_addr;
                    sel_data = cam_data;
                end else if (cam_we) begin
                    drop_inc = 1'b1;
                    oor_set  = 1'b1;
                end

                if (state_q == S_RUN) begin
                    // An out-of-range request is still granted (and discarded)
                    // so the engine cannot hang, but only when the camera did
                    // not win this cycle.
                    if (!cam_win && proc_req) begin
                        gnt = 1'b1;
                        if (proc_inr) begin
                            sel_we   = 1'b1;
                            sel_addr = proc_addr;
                            sel_data = proc_data;
                        end else begin
                            oor_set = 1'b1;
                        end
                    end
                    if (clr_start) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end

            S_CLEAR: begin
                sel_we   = 1'b1;
                sel_addr = cnt_q;
                sel_data = CLR_VAL;
                drop_inc = cam_we;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_PIX) begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        if (rst) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            drop_cnt_q <= '0;
            oor_err_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ram_we_q <= sel_we;
            if (sel_we) begin
                ram_addr_q <= sel_addr;
                ram_data_q <= sel_data;
            end
            if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (oor_set) begin
                oor_err_q <= 1'b1;
            end
            clr_busy_q <= (state_d == S_CLEAR);
            clr_done_q <= (state_d == S_DONE);
        end
    end

    assign proc_gnt = gnt;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign drop_cnt = drop_cnt_q;
    assign oor_err  = oor_err_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
module tb_fb_write_scheduler;

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 8;
    localparam int unsigned NPIX = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          proc_req;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_data;
    logic          proc_gnt;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [15:0]   drop_cnt;
    logic          oor_err;

    fb_write_scheduler #(
        .AW      (AW),
        .DW      (DW),
        .NPIX    (NPIX),
        .CLR_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cam_we    (cam_we),
        .cam_addr  (cam_addr),
        .cam_data  (cam_data),
        .proc_req  (proc_req),
        .proc_addr (proc_addr),
        .proc_data (proc_data),
        .proc_gnt  (proc_gnt),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .drop_cnt  (drop_cnt),
        .oor_err   (oor_err)
    );

    always #5 clk = ~clk;

    // Expected state of the write port after the next clock edge.
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            done;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame clear is a list of NPIX pending writes, then one
    // quiet "done" cycle; otherwise camera-over-processing arbitration.
    bit            m_valid = 0;
    bit            m_clear = 0;
    bit            m_done  = 0;
    int            m_idx   = 0;
    int            m_drop  = 0;
    bit            m_oor   = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_one();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic step(input bit r, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input bit pr, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input bit cs, output bit g);
        exp_t e;
        bit   eg;
        bit   cam_ok;
        @(posedge clk);
        #2;
        rst       = r;
        cam_we    = cw;
        cam_addr  = ca;
        cam_data  = cd;
        proc_req  = pr;
        proc_addr = pa;
        proc_data = pd;
        clr_start = cs;
        #1;
        if (m_valid) begin
            chk("clr_busy", 32'(clr_busy), 32'(m_clear));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("oor_err",  32'(oor_err),  32'(m_oor));
        end
        eg     = 0;
        e.we   = 0;
        e.addr = m_addr;
        e.data = m_data;
        e.done = 0;
        if (r) begin
            m_valid = 1;
            m_clear = 0;
            m_done  = 0;
            m_drop  = 0;
            m_oor   = 0;
            m_addr  = '0;
            m_data  = '0;
            e.addr  = '0;
            e.data  = '0;
        end else if (m_clear) begin
            e.we   = 1;
            e.addr = AW'(m_idx);
            e.data = 8'h00;
            e.done = (m_idx == NPIX - 1);
            if (cw) drop_one();
            m_idx++;
            if (m_idx == NPIX) begin
                m_clear = 0;
                m_done  = 1;
            end
        end else begin
            cam_ok = cw && (int'(ca) < NPIX);
            if (cam_ok) begin
                e.we   = 1;
                e.addr = ca;
                e.data = cd;
            end else if (cw) begin
                drop_one();
                m_oor = 1;
            end
            if (!m_done && !cam_ok && pr) begin
                eg = 1;
                if (int'(pa) < NPIX) begin
                    e.we   = 1;
                    e.addr = pa;
                    e.data = pd;
                end else begin
                    m_oor = 1;
                end
            end
            if (!m_done && cs) begin
                m_clear = 1;
                m_idx   = 0;
            end
            m_done = 0;
        end
        if (e.we) begin
            m_addr = e.addr;
            m_data = e.data;
        end
        chk("proc_gnt", 32'(proc_gnt), 32'(eg));
        exp_q.push_back(e);
        g = eg;
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0, g);
    endtask

    // Monitor: the write port value after each edge is compared against the
    // entry queued by the stimulus during the preceding cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ram_port", {7'd0, ram_we, ram_addr, ram_data, clr_done},
                                {7'd0, e.we, e.addr, e.data, e.done});
            end
        end
    end

    initial begin
        bit            g;
        bit            r;
        bit            cw;
        bit            cs;
        logic [AW-1:0] ca;
        bit            p_req;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        int            rst_left;

        rst = 1; cam_we = 0; cam_addr = '0; cam_data = '0;
        proc_req = 0; proc_addr = '0; proc_data = '0; clr_start = 0;

        // Reset, then idle.
        step(1, 0, '0, '0, 0, '0, '0, 0, g);
        step(1, 0, '0, '0, 0, '0, '0, 0, g);
        idle(3);
        chk("reset_ram_we", 32'(ram_we), 32'd0);

        // Processing write granted on the request cycle.
        step(0, 0, '0, '0, 1, 15'd5, 8'hAA, 0, g);
        idle(2);

        // Camera wins, processing waits one cycle.
        step(0, 1, 15'd7, 8'h11, 1, 15'd9, 8'hBB, 0, g);
        step(0, 0, '0, '0, 1, 15'd9, 8'hBB, 0, g);
        idle(2);

        // Full clear with the camera streaming throughout.
        step(0, 0, '0, '0, 0, '0, '0, 1, g);
        for (int i = 0; i < 20; i++) step(0, 1, 15'd1, 8'h22, 0, '0, '0, 0, g);
        chk("clear_drops", 32'(drop_cnt), 32'd16);
        idle(2);

        // Out-of-range camera pixel and processing request.
        step(1, 0, '0, '0, 0, '0, '0, 0, g);
        step(0, 1, 15'(NPIX), 8'h33, 0, '0, '0, 0, g);
        step(0, 0, '0, '0, 1, 15'h7FFF, 8'h44, 0, g);
        idle(1);
        chk("oor_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("oor_err_set", 32'(oor_err), 32'd1);
        idle(4);

        // Out-of-range request waits behind an in-range camera pixel.
        step(0, 1, 15'd2, 8'h55, 1, 15'h7FFF, 8'h66, 0, g);
        step(0, 0, '0, '0, 1, 15'h7FFF, 8'h66, 0, g);
        idle(2);

        // Reset part-way through a clear, then a fresh clear from address 0.
        step(1, 0, '0, '0, 0, '0, '0, 0, g);
        step(0, 0, '0, '0, 0, '0, '0, 1, g);
        idle(5);
        step(1, 0, '0, '0, 0, '0, '0, 0, g);
        idle(4);
        step(0, 0, '0, '0, 0, '0, '0, 1, g);
        idle(NPIX + 3);

        // Randomized traffic.
        p_req = 0; p_addr = '0; p_data = '0; rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r = 0;
            if (rst_left > 0) begin
                r = 1;
                rst_left--;
            end else if ($urandom_range(0, 399) == 0) begin
                r = 1;
                rst_left = $urandom_range(0, 1);
            end
            cw = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 7) == 0) ca = AW'($urandom_range(NPIX, 32767));
            else                           ca = AW'($urandom_range(0, NPIX - 1));
            if (!p_req && $urandom_range(0, 2) == 0) begin
                p_req  = 1;
                p_addr = ($urandom_range(0, 9) == 0) ? 15'h7FFF : AW'($urandom_range(0, NPIX - 1));
                p_data = DW'($urandom);
            end
            cs = ($urandom_range(0, 59) == 0);
            step(r, cw, ca, DW'($urandom), p_req, p_addr, p_data, cs, g);
            if (g) p_req = 0;
        end
        idle(3);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
